// File: rtl/seg_capture.sv
// Receive side of the multiplexed seven-segment link.
// Rebuilds four digit codes and the dp mask from an in-order anode sweep.
module seg_capture #(
    parameter int STABLE_CYCLES = 1,
    parameter int TIMEOUT       = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    input  logic       dp,
    output logic [4:0] digit0,
    output logic [4:0] digit1,
    output logic [4:0] digit2,
    output logic [4:0] digit3,
    output logic [3:0] dp_out,
    output logic       frame_valid,
    output logic       frame_pulse,
    output logic       seq_err
);

    localparam logic [3:0]  RUN_HIT = 4'(STABLE_CYCLES);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        CAPTURE   = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  exp_idx, exp_nx;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic        s_dp;
    logic [3:0]  run;
    logic        last_vld;
    logic [1:0]  last_idx;
    logic [15:0] tcnt;
    logic [4:0]  shadow [4];
    logic        sh_dp  [4];
    logic        idx_vld;
    logic [1:0]  idx;
    logic [4:0]  code;
    logic        same;
    logic        accept;
    logic        timeout_hit;
    logic        store;
    logic        commit;
    logic        err;

    assign same = {an, seg, dp} == {s_an, s_seg, s_dp};

    always_ff @(posedge clk) begin
        if (reset) begin
            s_an  <= '1;
            s_seg <= '1;
            s_dp  <= 1'b1;
            run   <= '0;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            s_dp  <= dp;
            run   <= same ? ((run == 4'd15) ? run : run + 4'd1) : 4'd1;
        end
    end

    always_comb begin
        idx_vld = 1'b1;
        idx     = 2'd0;
        unique case (s_an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx_vld = 1'b0;
        endcase
    end

    always_comb begin
        case (s_seg)
            7'b1000000: code = 5'd0;
            7'b1111001: code = 5'd1;
            7'b0100100: code = 5'd2;
            7'b0110000: code = 5'd3;
            7'b0011001: code = 5'd4;
            7'b0010010: code = 5'd5;
            7'b0000010: code = 5'd6;
            7'b1111000: code = 5'd7;
            7'b0000000: code = 5'd8;
            7'b0011000: code = 5'd9;
            7'b1111111: code = 5'd10;
            default:    code = 5'd31;
        endcase
    end

    // A held digit is taken once: the run must hit the target exactly
    assign accept = idx_vld && run == RUN_HIT
                    && !(last_vld && last_idx == idx);
    assign timeout_hit = !accept && tcnt == TO_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT_SYNC;
            exp_idx <= 2'd0;
        end else begin
            state   <= state_nx;
            exp_idx <= exp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        exp_nx   = exp_idx;
        if (accept) begin
            unique case (state)
                WAIT_SYNC: begin
                    if (idx == 2'd0) begin
                        state_nx = CAPTURE;
                        exp_nx   = 2'd1;
                    end
                end
                CAPTURE: begin
                    if (idx == exp_idx) begin
                        exp_nx = exp_idx + 2'd1;
                    end else if (idx == 2'd0) begin
                        exp_nx = 2'd1;
                    end else begin
                        state_nx = WAIT_SYNC;
                        exp_nx   = 2'd0;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_nx = WAIT_SYNC;
            exp_nx   = 2'd0;
        end
    end

    always_comb begin
        store  = 1'b0;
        commit = 1'b0;
        err    = 1'b0;
        if (accept) begin
            err = code == 5'd31;
            unique case (state)
                WAIT_SYNC: store = idx == 2'd0;
                CAPTURE: begin
                    if (idx == exp_idx) begin
                        store  = 1'b1;
                        commit = idx == 2'd3;
                    end else begin
                        err   = 1'b1;
                        store = idx == 2'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit0      <= 5'd10;
            digit1      <= 5'd10;
            digit2      <= 5'd10;
            digit3      <= 5'd10;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            frame_pulse <= 1'b0;
            seq_err     <= 1'b0;
            last_vld    <= 1'b0;
            last_idx    <= 2'd0;
            tcnt        <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                sh_dp[i]  <= 1'b0;
            end
        end else begin
            frame_pulse <= commit;
            seq_err     <= err;
            if (store) begin
                shadow[idx] <= code;
                sh_dp[idx]  <= ~s_dp;
            end
            if (commit) begin
                digit0      <= shadow[0];
                digit1      <= shadow[1];
                digit2      <= shadow[2];
                digit3      <= code;
                dp_out      <= {~s_dp, sh_dp[2], sh_dp[1], sh_dp[0]};
                frame_valid <= 1'b1;
            end else if (timeout_hit) begin
                frame_valid <= 1'b0;
            end
            if (accept) begin
                tcnt     <= '0;
                last_vld <= 1'b1;
                last_idx <= idx;
            end else if (timeout_hit) begin
                tcnt     <= '0;
                last_vld <= 1'b0;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: two instances (STABLE 1/TIMEOUT 16, STABLE 3/TIMEOUT 40)
// checked every cycle against a frame-assembly model plus literal spot checks.
module tb_seg_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    logic [4:0] act_dig [2][4];
    logic [3:0] act_dp  [2];
    logic       act_fv  [2];
    logic       act_fp  [2];
    logic       act_se  [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int fp_cnt [2] = '{0, 0};
    int se_cnt [2] = '{0, 0};

    logic [6:0] SEG [11] = '{7'b1000000, 7'b1111001, 7'b0100100,
                             7'b0110000, 7'b0011001, 7'b0010010,
                             7'b0000010, 7'b1111000, 7'b0000000,
                             7'b0011000, 7'b1111111};

    always #5 clk = ~clk;

    seg_capture #(.STABLE_CYCLES(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .seg(seg), .an(an), .dp(dp),
        .digit0(act_dig[0][0]), .digit1(act_dig[0][1]),
        .digit2(act_dig[0][2]), .digit3(act_dig[0][3]),
        .dp_out(act_dp[0]), .frame_valid(act_fv[0]),
        .frame_pulse(act_fp[0]), .seq_err(act_se[0])
    );

    seg_capture #(.STABLE_CYCLES(3), .TIMEOUT(40)) dut_b (
        .clk(clk), .reset(reset), .seg(seg), .an(an), .dp(dp),
        .digit0(act_dig[1][0]), .digit1(act_dig[1][1]),
        .digit2(act_dig[1][2]), .digit3(act_dig[1][3]),
        .dp_out(act_dp[1]), .frame_valid(act_fv[1]),
        .frame_pulse(act_fp[1]), .seq_err(act_se[1])
    );

    // ---------------- model ----------------
    logic [3:0] m_an   [2];
    logic [6:0] m_seg  [2];
    logic       m_dp   [2];
    int         m_run  [2];
    int         m_last [2];
    int         m_cnt  [2];
    int         m_idle [2];
    bit         m_sync [2];
    logic [4:0] pend   [2][4];
    logic       pdp    [2][4];
    logic [4:0] e_dig  [2][4];
    logic [3:0] e_dp   [2];
    logic       e_fv   [2];
    logic       e_fp   [2];
    logic       e_se   [2];

    function automatic int dec(input logic [6:0] s);
        for (int k = 0; k < 11; k++)
            if (s === SEG[k]) return k;
        return 31;
    endfunction

    function automatic int anode(input logic [3:0] a);
        int z = 0;
        int p = -1;
        for (int k = 0; k < 4; k++)
            if (a[k] === 1'b0) begin
                z++;
                p = k;
            end
        return (z == 1) ? p : -1;
    endfunction

    task automatic model_step(input int i);
        int idx;
        int code;
        int s;
        int t;
        bit acc;
        s = (i == 0) ? 1 : 3;
        t = (i == 0) ? 16 : 40;
        if (reset) begin
            for (int d = 0; d < 4; d++) e_dig[i][d] = 5'd10;
            e_dp[i]   = 4'd0;
            e_fv[i]   = 1'b0;
            e_fp[i]   = 1'b0;
            e_se[i]   = 1'b0;
            m_run[i]  = 0;
            m_last[i] = -1;
            m_sync[i] = 1'b0;
            m_cnt[i]  = 0;
            m_idle[i] = 0;
        end else begin
            e_fp[i] = 1'b0;
            e_se[i] = 1'b0;
            idx  = anode(m_an[i]);
            code = dec(m_seg[i]);
            acc  = idx >= 0 && m_run[i] == s && idx != m_last[i];
            if (acc) begin
                m_idle[i] = 0;
                m_last[i] = idx;
                if (code == 31) e_se[i] = 1'b1;
                if (m_sync[i] && idx == m_cnt[i]) begin
                    pend[i][idx] = 5'(code);
                    pdp[i][idx]  = ~m_dp[i];
                    m_cnt[i]++;
                    if (m_cnt[i] == 4) begin
                        for (int d = 0; d < 4; d++) e_dig[i][d] = pend[i][d];
                        e_dp[i] = {pdp[i][3], pdp[i][2], pdp[i][1], pdp[i][0]};
                        e_fv[i] = 1'b1;
                        e_fp[i] = 1'b1;
                        m_cnt[i] = 0;
                    end
                end else begin
                    if (m_sync[i]) e_se[i] = 1'b1;
                    if (idx == 0) begin
                        pend[i][0] = 5'(code);
                        pdp[i][0]  = ~m_dp[i];
                        m_cnt[i]   = 1;
                        m_sync[i]  = 1'b1;
                    end else begin
                        m_sync[i] = 1'b0;
                        m_cnt[i]  = 0;
                    end
                end
            end else begin
                m_idle[i]++;
                if (m_idle[i] == t) begin
                    e_fv[i]   = 1'b0;
                    m_sync[i] = 1'b0;
                    m_cnt[i]  = 0;
                    m_idle[i] = 0;
                    m_last[i] = -1;
                end
            end
            if ({an, seg, dp} === {m_an[i], m_seg[i], m_dp[i]})
                m_run[i] = (m_run[i] < 15) ? m_run[i] + 1 : 15;
            else
                m_run[i] = 1;
            m_an[i]  = an;
            m_seg[i] = seg;
            m_dp[i]  = dp;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                for (int d = 0; d < 4; d++)
                    chk($sformatf("u%0d_digit%0d", i, d),
                        32'(act_dig[i][d]), 32'(e_dig[i][d]));
                chk($sformatf("u%0d_dp_out", i), 32'(act_dp[i]), 32'(e_dp[i]));
                chk($sformatf("u%0d_frame_valid", i), 32'(act_fv[i]), 32'(e_fv[i]));
                chk($sformatf("u%0d_frame_pulse", i), 32'(act_fp[i]), 32'(e_fp[i]));
                chk($sformatf("u%0d_seq_err", i), 32'(act_se[i]), 32'(e_se[i]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (act_fp[i] === 1'b1) fp_cnt[i]++;
            if (act_se[i] === 1'b1) se_cnt[i]++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [6:0] segof(input int code);
        return (code == 31) ? 7'b1010101 : SEG[code];
    endfunction

    task automatic drive(input logic [3:0] a, input logic [6:0] s,
                         input logic d);
        @(negedge clk);
        an  = a;
        seg = s;
        dp  = d;
    endtask

    task automatic put(input int i, input int code, input logic dpon,
                       input int hold, input int glitch);
        for (int h = 0; h < hold; h++)
            drive(~4'(1 << i), (h == glitch) ? SEG[8] : segof(code), ~dpon);
    endtask

    task automatic sweep(input int c0, input int c1, input int c2,
                         input int c3, input logic [3:0] m,
                         input int hold, input int glitch);
        put(0, c0, m[0], hold, -1);
        put(1, c1, m[1], hold, glitch);
        put(2, c2, m[2], hold, -1);
        put(3, c3, m[3], hold, -1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(4'hF, 7'h7F, 1'b1);
    endtask

    task automatic lit_digits(input string nm, input int u, input int a,
                              input int b, input int c, input int d);
        chk({nm, "_d0"}, 32'(act_dig[u][0]), a);
        chk({nm, "_d1"}, 32'(act_dig[u][1]), b);
        chk({nm, "_d2"}, 32'(act_dig[u][2]), c);
        chk({nm, "_d3"}, 32'(act_dig[u][3]), d);
    endtask

    initial begin
        int f0;
        int s0;
        reset = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        repeat (3) @(negedge clk);
        lit_digits("rst", 0, 10, 10, 10, 10);
        chk("rst_dp", 32'(act_dp[0]), 0);
        chk("rst_fv", 32'(act_fv[0]), 0);
        chk("rst_fp", 32'(act_fp[0]), 0);
        chk("rst_se", 32'(act_se[0]), 0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // basic sweep, one cycle per anode
        sweep(4, 0, 2, 6, 4'b0010, 1, -1);
        idle(1);
        chk("t1_partial_d0", 32'(act_dig[0][0]), 10);
        chk("t1_partial_fp", 32'(act_fp[0]), 0);
        @(negedge clk);
        lit_digits("t1", 0, 4, 0, 2, 6);
        chk("t1_dp", 32'(act_dp[0]), 32'b0010);
        chk("t1_fp", 32'(act_fp[0]), 1);
        chk("t1_fv", 32'(act_fv[0]), 1);
        @(negedge clk);
        chk("t1_fp_drop", 32'(act_fp[0]), 0);

        // back-to-back sweeps, digit2 changes in the second
        f0 = fp_cnt[0];
        sweep(4, 0, 2, 6, 4'b0010, 1, -1);
        sweep(4, 0, 9, 6, 4'b0010, 1, -1);
        idle(1);
        chk("t2_d2_before", 32'(act_dig[0][2]), 2);
        @(negedge clk);
        lit_digits("t2", 0, 4, 0, 9, 6);
        chk("t2_pulses", 32'(fp_cnt[0] - f0), 2);

        // STABLE_CYCLES=3 with a one-cycle glitch on digit1
        f0 = fp_cnt[1];
        sweep(1, 2, 3, 4, 4'b1000, 5, 1);
        sweep(7, 8, 5, 0, 4'b0001, 5, 1);
        idle(3);
        lit_digits("t3", 1, 7, 8, 5, 0);
        chk("t3_dp", 32'(act_dp[1]), 32'b0001);
        chk("t3_fv", 32'(act_fv[1]), 1);
        chk("t3_pulses", 32'(fp_cnt[1] - f0), 2);

        // out-of-order sweep 0,1,3 then a clean sweep
        f0 = fp_cnt[0];
        s0 = se_cnt[0];
        put(0, 1, 1'b0, 1, -1);
        put(1, 1, 1'b0, 1, -1);
        put(3, 5, 1'b0, 1, -1);
        idle(2);
        chk("t4_seq_err", 32'(se_cnt[0] - s0), 1);
        chk("t4_no_pulse", 32'(fp_cnt[0] - f0), 0);
        lit_digits("t4_hold", 0, 7, 8, 5, 0);
        chk("t4_fv_kept", 32'(act_fv[0]), 1);
        sweep(3, 3, 3, 3, 4'b0000, 1, -1);
        idle(1);
        @(negedge clk);
        chk("t4_recover", 32'(fp_cnt[0] - f0), 1);
        lit_digits("t4_new", 0, 3, 3, 3, 3);

        // undecodable pattern on digit2
        s0 = se_cnt[0];
        sweep(1, 2, 31, 3, 4'b0000, 1, -1);
        idle(1);
        @(negedge clk);
        lit_digits("t5", 0, 1, 2, 31, 3);
        chk("t5_seq_err", 32'(se_cnt[0] - s0), 1);

        // timeout after a valid frame
        sweep(5, 6, 7, 8, 4'b1111, 1, -1);
        idle(1);
        @(negedge clk);
        chk("t6_fv_set", 32'(act_fv[0]), 1);
        repeat (15) @(negedge clk);
        chk("t6_fv_at15", 32'(act_fv[0]), 1);
        @(negedge clk);
        chk("t6_fv_at16", 32'(act_fv[0]), 0);
        lit_digits("t6_hold", 0, 5, 6, 7, 8);
        chk("t6_dp_hold", 32'(act_dp[0]), 32'b1111);

        // reset in the middle of a sweep
        sweep(1, 1, 1, 1, 4'b0000, 1, -1);
        idle(1);
        @(negedge clk);
        chk("t7_fv_pre", 32'(act_fv[0]), 1);
        put(0, 2, 1'b1, 1, -1);
        put(1, 3, 1'b0, 1, -1);
        put(2, 4, 1'b0, 1, -1);
        reset = 1'b1;
        @(negedge clk);
        lit_digits("t7_rst", 0, 10, 10, 10, 10);
        chk("t7_rst_dp", 32'(act_dp[0]), 0);
        chk("t7_rst_fv", 32'(act_fv[0]), 0);
        chk("t7_rst_fp", 32'(act_fp[0]), 0);
        chk("t7_rst_se", 32'(act_se[0]), 0);
        reset = 1'b0;
        sweep(9, 8, 7, 6, 4'b0100, 1, -1);
        idle(1);
        @(negedge clk);
        lit_digits("t7_after", 0, 9, 8, 7, 6);
        chk("t7_after_dp", 32'(act_dp[0]), 32'b0100);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
